// File: rtl/intc_nch.sv
// rtl/intc_nch.sv - NCH-channel edge-triggered interrupt controller with vector table
module intc_nch #(
  parameter  int NCH = 8,
  localparam int IDW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   irq_in,
  input  logic [31:0]      input_addr,
  input  logic [31:0]      write_data,
  input  logic             write_enable,
  output logic [31:0]      read_data,
  input  logic             IACK,
  output logic             IRQ,
  output logic [31:0]      isr_addr,
  output logic [IDW-1:0]   priority_select
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  logic [NCH-1:0] r_prev;
  logic [NCH-1:0] r_pending;
  logic [NCH-1:0] r_enable;
  logic [31:0]    r_vector [NCH];
  logic [1:0]     r_state;
  logic [IDW-1:0] r_cur_id;
  logic           r_irq;

  logic [5:0]     w_off;
  logic           w_sel_pend;
  logic           w_sel_en;
  logic           w_sel_stat;
  logic           w_sel_eoi;
  logic           w_vec_hit;
  logic [IDW-1:0] w_vec_sel;
  logic           w_addr_unused;
  logic [NCH-1:0] w_edge;
  logic [NCH-1:0] w_eligible;
  logic           w_any;
  logic [IDW-1:0] w_winner;
  logic           w_iack;
  logic           w_eoi;
  logic [NCH-1:0] w_w1c;
  logic [NCH-1:0] w_ack_clr;
  logic [1:0]     w_nstate;
  logic [IDW-1:0] w_ncur;

  // Word-offset decode; only addr[7:2] participates.
  assign w_off         = input_addr[7:2];
  assign w_sel_pend    = (w_off == 6'd0);
  assign w_sel_en      = (w_off == 6'd1);
  assign w_sel_stat    = (w_off == 6'd2);
  assign w_sel_eoi     = (w_off == 6'd3);
  assign w_vec_hit     = (w_off >= 6'd16) && ({1'b0, w_off} < 7'(16 + NCH));
  assign w_vec_sel     = IDW'(w_off - 6'd16);
  assign w_addr_unused = ^{input_addr[31:8], input_addr[1:0]};

  assign w_edge     = irq_in & ~r_prev;
  assign w_eligible = r_pending & r_enable;
  assign w_any      = |w_eligible;
  assign w_iack     = IACK && (r_state == ST_REQ);
  assign w_eoi      = write_enable && w_sel_eoi && (r_state == ST_SERV);
  assign w_w1c      = (write_enable && w_sel_pend) ? write_data[NCH-1:0] : '0;
  assign w_ack_clr  = w_iack ? (NCH'(1) << r_cur_id) : '0;

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = IDW'(i);
    end
  end

  // Edge latch, pending/enable bookkeeping and vector table writes; a new edge beats any clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_enable  <= '1;
      for (int i = 0; i < NCH; i++) r_vector[i] <= '0;
    end else begin
      r_prev    <= irq_in;
      r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_edge;
      if (write_enable && w_sel_en) r_enable <= write_data[NCH-1:0];
      if (write_enable && w_vec_hit) r_vector[w_vec_sel] <= write_data;
    end
  end

  // Request/service handshake next-state; IACK in REQ outranks the no-longer-eligible exit.
  always_comb begin
    w_nstate = r_state;
    w_ncur   = r_cur_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_nstate = ST_REQ;
          w_ncur   = w_winner;
        end
      end
      ST_REQ: begin
        if (w_iack) begin
          w_nstate = ST_SERV;
        end else if (!w_any) begin
          w_nstate = ST_IDLE;
        end else begin
          w_ncur = w_winner;
        end
      end
      ST_SERV: begin
        if (w_eoi) w_nstate = ST_IDLE;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  // FSM state, current channel and registered IRQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cur_id <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cur_id <= w_ncur;
      r_irq    <= (w_nstate == ST_REQ);
    end
  end

  // Combinational register read; unmapped offsets and unused bits return 0.
  always_comb begin
    read_data = '0;
    if (w_sel_pend) begin
      read_data[NCH-1:0] = r_pending;
    end else if (w_sel_en) begin
      read_data[NCH-1:0] = r_enable;
    end else if (w_sel_stat) begin
      read_data[1:0]       = r_state;
      read_data[8 +: IDW]  = r_cur_id;
    end else if (w_vec_hit) begin
      read_data = r_vector[w_vec_sel];
    end
  end

  assign IRQ             = r_irq;
  assign priority_select = r_cur_id;
  assign isr_addr        = r_vector[r_cur_id];

endmodule
